// File: rtl/hash_byte_feeder.sv
// hash_byte_feeder: buffers host bytes and end-of-message markers in a FIFO
// and replays each message to full_hash. A message starts with a start pulse,
// sends each byte over the F_dr/F_rtr four-phase handshake, and ends with an
// End_of_File handshake. The feeder then waits for H_ready before it begins
// the next message.
// Optional feature: define HASH_FEEDER_LEN_COUNT_EN to add a saturating
// per-message byte counter. Its result appears on the msg_len port.
module hash_byte_feeder #(
  parameter int DEPTH = 16
`ifdef HASH_FEEDER_LEN_COUNT_EN
  ,
  parameter int LEN_W = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic                    in_eof,
  output logic                    in_ready,
  output logic                    start,
  output logic [7:0]              Byte,
  output logic                    F_dr,
  output logic                    End_of_File,
  input  logic                    F_rtr,
  input  logic                    H_ready,
  output logic                    msg_done,
  output logic [$clog2(DEPTH):0]  fifo_level
`ifdef HASH_FEEDER_LEN_COUNT_EN
  ,
  output logic [LEN_W-1:0]        msg_len
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_FETCH,
    S_B_REQ,
    S_B_HOLD,
    S_B_REL,
    S_E_WAIT,
    S_E_REQ,
    S_H_WAIT
  } state_t;

  state_t          state;
  state_t          state_nx;

  // Each entry is {eof, data}. The extra pointer MSB tells full from empty.
  logic [8:0]      mem [DEPTH];
  logic [LW-1:0]   wr_ptr;
  logic [LW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [8:0]      head;

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == LW'(DEPTH));
  assign empty      = (wr_ptr == rd_ptr);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign head       = mem[rd_ptr[AW-1:0]];

  // FIFO storage. Data entries need no reset; only the pointers track validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_eof, in_data};
    end
  end

  // FIFO pointers. The asynchronous reset discards any buffered partial message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + LW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + LW'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and FIFO pop. A byte leaves the FIFO in B_HOLD.
  // A marker leaves when its End_of_File handshake completes.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      S_IDLE:   if (!empty) state_nx = S_START;
      S_START:  state_nx = S_FETCH;
      S_FETCH:  if (!empty) state_nx = head[8] ? S_E_WAIT : S_B_REQ;
      S_B_REQ:  if (F_rtr) state_nx = S_B_HOLD;
      S_B_HOLD: begin
        pop      = 1'b1;
        state_nx = S_B_REL;
      end
      S_B_REL:  if (!F_rtr) state_nx = S_FETCH;
      S_E_WAIT: if (F_rtr) state_nx = S_E_REQ;
      S_E_REQ: begin
        if (!F_rtr) begin
          pop      = 1'b1;
          state_nx = S_H_WAIT;
        end
      end
      S_H_WAIT: if (H_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Registered outputs. Strobes are decoded from the next state, so each one
  // is high exactly while the FSM occupies the matching state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start       <= 1'b0;
      F_dr        <= 1'b0;
      End_of_File <= 1'b0;
      msg_done    <= 1'b0;
      Byte        <= 8'h00;
    end else begin
      start       <= (state_nx == S_START);
      F_dr        <= (state_nx == S_B_REQ) || (state_nx == S_B_HOLD);
      End_of_File <= (state_nx == S_E_REQ);
      msg_done    <= (state == S_H_WAIT) && H_ready;
      if ((state == S_FETCH) && (state_nx == S_B_REQ)) begin
        Byte <= head[7:0];
      end
    end
  end

`ifdef HASH_FEEDER_LEN_COUNT_EN
  logic [LEN_W-1:0] len_cnt;

  // Per-message byte count. It saturates at all-ones and is published when
  // the End_of_File handshake completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt <= '0;
      msg_len <= '0;
    end else begin
      if (state == S_START) begin
        len_cnt <= '0;
      end else if ((state == S_B_HOLD) && (len_cnt != '1)) begin
        len_cnt <= len_cnt + LEN_W'(1);
      end
      if ((state == S_E_REQ) && !F_rtr) begin
        msg_len <= len_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hash_byte_feeder.sv
// Bench for hash_byte_feeder. The host side pushes directed messages and
// queues the expected entries. A hash model answers the handshakes with
// random delays and compares every delivered byte and marker against the queue.
module tb_hash_byte_feeder;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_eof;
  logic          in_ready;
  logic          start;
  logic [7:0]    Byte;
  logic          F_dr;
  logic          End_of_File;
  logic          F_rtr;
  logic          H_ready;
  logic          msg_done;
  logic [LW-1:0] fifo_level;
`ifdef HASH_FEEDER_LEN_COUNT_EN
  logic [15:0]   msg_len;
`endif

  hash_byte_feeder #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_eof      (in_eof),
    .in_ready    (in_ready),
    .start       (start),
    .Byte        (Byte),
    .F_dr        (F_dr),
    .End_of_File (End_of_File),
    .F_rtr       (F_rtr),
    .H_ready     (H_ready),
    .msg_done    (msg_done),
    .fifo_level  (fifo_level)
`ifdef HASH_FEEDER_LEN_COUNT_EN
    ,
    .msg_len     (msg_len)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  int         len_q[$];
  int         cur_len = 0;

  int  start_cnt = 0, done_cnt = 0, msg_bytes = 0, byte_total = 0, last_len = 0;
  bit  bfm_en = 1'b1, lat_arm = 1'b0;
  int  push_cyc0 = -1, start_cyc = -1, fdr_cyc = -1;

  byte ciao[9] = '{8'h43, 8'h69, 8'h61, 8'h6F, 8'h4D, 8'h6F, 8'h6E, 8'h64, 8'h6F};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic sb_check(input bit eof, input logic [7:0] d);
    logic [8:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_entry: got eof=%0d data=%02h, expected nothing (queue empty)", eof, d);
    end else begin
      e = exp_q.pop_front();
      if ((e[8] != eof) || (!eof && (e[7:0] != d))) begin
        errors++;
        $display("FAIL sb_entry: got eof=%0d data=%02h, expected eof=%0d data=%02h",
                 eof, d, e[8], e[7:0]);
      end
    end
  endtask

  // Hash model and output monitor
  typedef enum {R_IDLE, R_READY, R_HOLD, R_DROP} rstate_t;
  rstate_t    rs = R_IDLE;
  int         rdly = 0;
  int         hdly = -1;
  logic [7:0] cap;

  always @(negedge clk) begin
    int l;
    if (!rst_n) begin
      F_rtr   = 1'b0;
      H_ready = 1'b0;
      rs      = R_IDLE;
      rdly    = 0;
      hdly    = -1;
    end else begin
      if (start) begin
        chk("start_after_prev_done", start_cnt, done_cnt);
        if (lat_arm && start_cyc < 0) start_cyc = cyc;
        start_cnt++;
        msg_bytes = 0;
      end
      if (msg_done) begin
        chk("msg_done_needs_hready", int'(H_ready), 1);
`ifdef HASH_FEEDER_LEN_COUNT_EN
        chk("msg_len", int'(msg_len), last_len);
`endif
        done_cnt++;
        H_ready = 1'b0;
      end
      if (F_dr && lat_arm && fdr_cyc < 0) fdr_cyc = cyc;
      if (hdly > 0) hdly--;
      else if (hdly == 0) begin
        H_ready = 1'b1;
        hdly    = -1;
      end
      case (rs)
        R_IDLE: begin
          if (bfm_en) begin
            if (rdly > 0) rdly--;
            else begin
              F_rtr = 1'b1;
              rs    = R_READY;
            end
          end
        end
        R_READY: begin
          if (F_dr) begin
            cap = Byte;
            sb_check(1'b0, Byte);
            msg_bytes++;
            byte_total++;
            rs = R_HOLD;
          end else if (End_of_File) begin
            sb_check(1'b1, 8'h00);
            chk("eof_without_fdr", int'(F_dr), 0);
            l = (len_q.size() > 0) ? len_q.pop_front() : -1;
            chk("bytes_per_msg", msg_bytes, l);
            last_len = l;
            rdly = $urandom_range(5, 0);
            hdly = rdly + $urandom_range(6, 2);
            rs   = R_DROP;
          end else if (!bfm_en) begin
            F_rtr = 1'b0;
            rs    = R_IDLE;
          end
        end
        R_HOLD: begin
          if (F_dr) chk("byte_stable", int'(Byte), int'(cap));
          else begin
            rdly = $urandom_range(5, 0);
            rs   = R_DROP;
          end
        end
        R_DROP: begin
          if (rdly > 0) rdly--;
          else begin
            F_rtr = 1'b0;
            rdly  = $urandom_range(5, 0);
            rs    = R_IDLE;
          end
        end
        default: rs = R_IDLE;
      endcase
    end
  end

  task automatic push(input bit eof, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_eof   = eof;
    in_data  = d;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready stuck at 0, expected 1 within 3000 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back({eof, d});
    if (eof) begin
      len_q.push_back(cur_len);
      cur_len = 0;
    end else begin
      cur_len++;
    end
    #1;
    if (lat_arm && push_cyc0 < 0) push_cyc0 = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, done_cnt, target);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, int'(start), 0);
    chk({tag, "_F_dr"}, int'(F_dr), 0);
    chk({tag, "_eof"}, int'(End_of_File), 0);
    chk({tag, "_msg_done"}, int'(msg_done), 0);
    chk({tag, "_Byte"}, int'(Byte), 0);
    chk({tag, "_fifo_level"}, int'(fifo_level), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
`ifdef HASH_FEEDER_LEN_COUNT_EN
    chk({tag, "_msg_len"}, int'(msg_len), 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_eof   = 1'b0;
    in_data  = 8'h00;
    F_rtr    = 1'b0;
    H_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;

    // Normal message with latency measurement
    lat_arm    = 1'b1;
    byte_total = 0;
    for (int i = 0; i < 9; i++) push(1'b0, ciao[i]);
    push(1'b1, 8'h00);
    wait_done(1, 3000, "t1_done");
    chk("lat_push_to_start", start_cyc - push_cyc0, 1);
    chk("lat_push_to_fdr", fdr_cyc - push_cyc0, 3);
    lat_arm = 1'b0;
    chk("t1_start_count", start_cnt, 1);
    chk("t1_byte_count", byte_total, 9);
    chk("t1_queue_drained", exp_q.size(), 0);

    // Empty message
    byte_total = 0;
    push(1'b1, 8'h00);
    wait_done(2, 3000, "t2_done");
    chk("t2_start_count", start_cnt, 2);
    chk("t2_byte_count", byte_total, 0);
    chk("t2_queue_drained", exp_q.size(), 0);

    // Full FIFO with the hash stalled
    bfm_en     = 1'b0;
    byte_total = 0;
    repeat (4) @(negedge clk);
    fork
      begin
        for (int i = 0; i < 20; i++) push(1'b0, 8'hA0 + 8'(i));
        push(1'b1, 8'h00);
      end
    join_none
    n = 0;
    while (fifo_level != LW'(DEPTH) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t3_level_full", int'(fifo_level), DEPTH);
    chk("t3_in_ready_low", int'(in_ready), 0);
    repeat (10) @(negedge clk);
    chk("t3_level_held", int'(fifo_level), DEPTH);
    chk("t3_no_bytes_while_stalled", byte_total, 0);
    bfm_en = 1'b1;
    wait fork;
    wait_done(3, 6000, "t3_done");
    chk("t3_byte_count", byte_total, 20);
    chk("t3_queue_drained", exp_q.size(), 0);

    // Reset in the middle of a message
    byte_total = 0;
    for (int i = 0; i < 9; i++) push(1'b0, ciao[i]);
    push(1'b1, 8'h00);
    n = 0;
    while (byte_total < 4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reached_4th_byte", byte_total, 4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    len_q.delete();
    cur_len   = 0;
    start_cnt = 0;
    done_cnt  = 0;
    msg_bytes = 0;
    #1;
    chk_reset_outputs("midrst");
    repeat (5) @(negedge clk);
    chk("midrst_level_held", int'(fifo_level), 0);
    rst_n      = 1'b1;
    byte_total = 0;
    for (int i = 0; i < 9; i++) push(1'b0, ciao[i]);
    push(1'b1, 8'h00);
    wait_done(1, 3000, "t4_done");
    chk("t4_byte_count", byte_total, 9);
    chk("t4_queue_drained", exp_q.size(), 0);

    // Back-to-back messages
    byte_total = 0;
    push(1'b0, 8'h61);
    push(1'b0, 8'h62);
    push(1'b1, 8'h00);
    push(1'b0, 8'h63);
    push(1'b1, 8'h00);
    wait_done(3, 4000, "t5_done");
    chk("t5_start_count", start_cnt, 3);
    chk("t5_byte_count", byte_total, 3);
    chk("t5_queue_drained", exp_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
